// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong game controller.
// Holds the state encoding, parameter defaults and frame-counter sizing helper.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SERVE    = 3'd1,
      PLAY     = 3'd2,
      POINT    = 3'd3,
      GAMEOVER = 3'd4
   } game_state_t;

   localparam int unsigned DEF_WIN_SCORE    = 7;
   localparam int unsigned DEF_SERVE_FRAMES = 60;
   localparam int unsigned DEF_POINT_FRAMES = 30;
   localparam int unsigned SCORE_W          = 4;

   // Frame counter must hold the larger hold time, never narrower than 6 bits.
   function automatic int unsigned frame_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      int unsigned w;
      m = (a > b) ? a : b;
      w = $clog2(m + 1);
      return (w < 6) ? 6 : w;
   endfunction

endpackage

// File: rtl/pong_step_seq.sv
// Per-frame step sequencer: paddle, ball, collide strobes on consecutive cycles.
// A 2-bit phase counter tracks the sequence; abort kills it with no further strobes.
module pong_step_seq (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_start,
   input  logic enable,
   input  logic abort,
   output logic paddle_step,
   output logic ball_step,
   output logic collide_chk,
   output logic overrun
);

   logic [1:0] phase;
   logic       busy;
   logic       launch;

   assign busy   = (phase != 2'd0);
   assign launch = frame_start & enable & ~abort & ~busy;

   // Derived from the registered phase so a dropped pulse is flagged in its own cycle.
   assign overrun = frame_start & busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase       <= '0;
         paddle_step <= 1'b0;
         ball_step   <= 1'b0;
         collide_chk <= 1'b0;
      end else if (abort) begin
         phase       <= '0;
         paddle_step <= 1'b0;
         ball_step   <= 1'b0;
         collide_chk <= 1'b0;
      end else begin
         paddle_step <= launch;
         ball_step   <= (phase == 2'd1);
         collide_chk <= (phase == 2'd2);
         if (launch) begin
            phase <= 2'd1;
         end else if (busy) begin
            phase <= phase + 2'd1;
         end
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/point/gameover FSM, scoring and frame timing.
// Per-frame step strobes are delegated to pong_step_seq.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
   parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
   parameter int unsigned POINT_FRAMES = DEF_POINT_FRAMES
) (
   input  logic         pixel_clk,
   input  logic         rst_n,
   input  logic         start_btn,
   input  logic         frame_start,
   input  logic         score_player_evt,
   input  logic         score_ai_evt,
   output logic [2:0]   game_state,
   output logic         serve_req,
   output logic         paddle_step,
   output logic         ball_step,
   output logic         collide_chk,
   output logic [3:0]   score_player,
   output logic [3:0]   score_ai,
   output logic         winner,
   output logic         overrun
);

   localparam int unsigned FRAME_W = frame_width(SERVE_FRAMES, POINT_FRAMES);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
   localparam logic [FRAME_W-1:0] SERVE_LAST = FRAME_W'(SERVE_FRAMES - 1);
   localparam logic [FRAME_W-1:0] POINT_LAST = FRAME_W'(POINT_FRAMES - 1);

   game_state_t        state, state_d;
   logic [FRAME_W-1:0] frame_cnt, frame_d;
   logic [SCORE_W-1:0] score_p_d, score_a_d;
   logic               winner_d;
   logic               serve_d;
   logic               abort;
   logic               start_q;
   logic               start_rise;

   assign start_rise = start_btn & ~start_q;
   assign game_state = state;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         frame_cnt    <= '0;
         score_player <= '0;
         score_ai     <= '0;
         winner       <= 1'b0;
         serve_req    <= 1'b0;
         start_q      <= 1'b1;
      end else begin
         state        <= state_d;
         frame_cnt    <= frame_d;
         score_player <= score_p_d;
         score_ai     <= score_a_d;
         winner       <= winner_d;
         serve_req    <= serve_d;
         start_q      <= start_btn;
      end
   end

   always_comb begin
      state_d   = state;
      score_p_d = score_player;
      score_a_d = score_ai;
      winner_d  = winner;
      serve_d   = 1'b0;
      abort     = 1'b0;

      case (state)
         IDLE, GAMEOVER: begin
            if (start_rise) begin
               state_d   = SERVE;
               score_p_d = '0;
               score_a_d = '0;
               winner_d  = 1'b0;
               serve_d   = 1'b1;
            end
         end
         SERVE: begin
            if (frame_start && frame_cnt == SERVE_LAST) begin
               state_d = PLAY;
            end
         end
         PLAY: begin
            // Simultaneous events credit only the player.
            if (score_player_evt) begin
               abort   = 1'b1;
               state_d = POINT;
               if (score_player != WIN) begin
                  score_p_d = score_player + 1'b1;
               end
            end else if (score_ai_evt) begin
               abort   = 1'b1;
               state_d = POINT;
               if (score_ai != WIN) begin
                  score_a_d = score_ai + 1'b1;
               end
            end
         end
         POINT: begin
            if (score_player == WIN || score_ai == WIN) begin
               state_d  = GAMEOVER;
               winner_d = (score_player == WIN);
            end else if (frame_start && frame_cnt == POINT_LAST) begin
               state_d = SERVE;
               serve_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state) begin
         frame_d = '0;
      end else if (frame_start && (state == SERVE || state == POINT)) begin
         frame_d = frame_cnt + 1'b1;
      end else begin
         frame_d = frame_cnt;
      end
   end

   pong_step_seq u_step_seq (
      .clk         (pixel_clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .enable      (state == PLAY),
      .abort       (abort),
      .paddle_step (paddle_step),
      .ball_step   (ball_step),
      .collide_chk (collide_chk),
      .overrun     (overrun)
   );

endmodule
